// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : Fetches bytes from program memory, assembles 3-byte instructions
//            (opcode, arg1, arg2) and queues them for the core.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter int                ADDR_W     = 8,
    parameter int                DEPTH      = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_instr_read,
    output logic              o_instr_ready,
    output logic [7:0]        o_opcode,
    output logic [7:0]        o_arg1,
    output logic [7:0]        o_arg2,
    output logic [ADDR_W-1:0] o_instr_addr,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic              i_mem_ready,
    input  logic [7:0]        i_mem_data,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_redirect_addr
);

    localparam int                 C_PTR_W = $clog2(DEPTH);
    localparam int                 C_CNT_W = C_PTR_W + 1;
    localparam logic [C_CNT_W-1:0] C_DEPTH = C_CNT_W'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ_OP = 3'd1,
        S_REQ_A1 = 3'd2,
        S_REQ_A2 = 3'd3,
        S_FLUSH  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]   entry_addr_q, entry_addr_d;
    logic [7:0]          op_q, op_d;
    logic [7:0]          a1_q, a1_d;
    logic [C_PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [C_PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [C_CNT_W-1:0]  count_q, count_d;

    logic [7:0]          fifo_op_q   [DEPTH];
    logic [7:0]          fifo_op_d   [DEPTH];
    logic [7:0]          fifo_a1_q   [DEPTH];
    logic [7:0]          fifo_a1_d   [DEPTH];
    logic [7:0]          fifo_a2_q   [DEPTH];
    logic [7:0]          fifo_a2_d   [DEPTH];
    logic [ADDR_W-1:0]   fifo_addr_q [DEPTH];
    logic [ADDR_W-1:0]   fifo_addr_d [DEPTH];

    logic                w_pop;
    logic                w_beat;
    logic                w_push;
    logic [C_CNT_W-1:0]  w_cnt_after_pop;
    logic [C_CNT_W-1:0]  w_cnt_after_push;

    assign w_pop            = (count_q != '0) && i_instr_read;
    assign w_beat           = mem_req_q && i_mem_ready;
    assign w_push           = (state_q == S_REQ_A2) && w_beat;
    assign w_cnt_after_pop  = count_q - C_CNT_W'(w_pop);
    assign w_cnt_after_push = w_cnt_after_pop + 1'b1;

    assign o_instr_ready = (count_q != '0);
    assign o_opcode      = fifo_op_q[rd_ptr_q];
    assign o_arg1        = fifo_a1_q[rd_ptr_q];
    assign o_arg2        = fifo_a2_q[rd_ptr_q];
    assign o_instr_addr  = fifo_addr_q[rd_ptr_q];
    assign o_mem_req     = mem_req_q;
    assign o_mem_addr    = mem_addr_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        entry_addr_d = entry_addr_q;
        op_d         = op_q;
        a1_d         = a1_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        fifo_op_d    = fifo_op_q;
        fifo_a1_d    = fifo_a1_q;
        fifo_a2_d    = fifo_a2_q;
        fifo_addr_d  = fifo_addr_q;

        case (state_q)
            S_IDLE: begin
                if (w_cnt_after_pop < C_DEPTH) begin
                    state_d = S_REQ_OP;
                end
            end
            S_REQ_OP: begin
                if (w_beat) begin
                    op_d         = i_mem_data;
                    entry_addr_d = pc_q;
                    pc_d         = pc_q + 1'b1;
                    state_d      = S_REQ_A1;
                end
            end
            S_REQ_A1: begin
                if (w_beat) begin
                    a1_d    = i_mem_data;
                    pc_d    = pc_q + 1'b1;
                    state_d = S_REQ_A2;
                end
            end
            S_REQ_A2: begin
                if (w_beat) begin
                    pc_d    = pc_q + 1'b1;
                    state_d = (w_cnt_after_push < C_DEPTH) ? S_REQ_OP : S_IDLE;
                end
            end
            S_FLUSH: begin
                state_d = S_REQ_OP;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (w_push) begin
            fifo_op_d[wr_ptr_q]   = op_q;
            fifo_a1_d[wr_ptr_q]   = a1_q;
            fifo_a2_d[wr_ptr_q]   = i_mem_data;
            fifo_addr_d[wr_ptr_q] = entry_addr_q;
            wr_ptr_d              = wr_ptr_q + 1'b1;
        end
        count_d = count_q - C_CNT_W'(w_pop) + C_CNT_W'(w_push);

        // Redirect overrides any pop, push or beat seen in the same cycle
        if (i_redirect) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            pc_d     = i_redirect_addr;
            state_d  = S_FLUSH;
        end

        mem_req_d  = (state_d == S_REQ_OP) || (state_d == S_REQ_A1) ||
                     (state_d == S_REQ_A2);
        mem_addr_d = pc_d;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_ADDR;
            mem_addr_q   <= '0;
            mem_req_q    <= 1'b0;
            entry_addr_q <= '0;
            op_q         <= '0;
            a1_q         <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_op_q[i]   <= '0;
                fifo_a1_q[i]   <= '0;
                fifo_a2_q[i]   <= '0;
                fifo_addr_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            mem_addr_q   <= mem_addr_d;
            mem_req_q    <= mem_req_d;
            entry_addr_q <= entry_addr_d;
            op_q         <= op_d;
            a1_q         <= a1_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            fifo_op_q    <= fifo_op_d;
            fifo_a1_q    <= fifo_a1_d;
            fifo_a2_q    <= fifo_a2_d;
            fifo_addr_q  <= fifo_addr_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Brief    : Self-checking bench for instr_fetch_unit against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       instr_read;
    logic       instr_ready;
    logic [7:0] opcode, arg1, arg2, instr_addr;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ready;
    logic [7:0] mem_data;
    logic       redirect;
    logic [7:0] redirect_addr;

    logic       wp_instr_ready, wp_mem_req;
    logic [7:0] wp_opcode, wp_arg1, wp_arg2, wp_instr_addr, wp_mem_addr, wp_mem_data;

    logic [7:0] mem [256];

    logic [7:0] model_pc;
    logic [7:0] cur_addr;
    int         beat_idx;
    logic [7:0] exp_q [$];

    int pass_cnt  = 0;
    int total_cnt = 0;

    assign mem_data    = mem[mem_addr];
    assign wp_mem_data = mem[wp_mem_addr];

    always #5 clk = ~clk;

    instr_fetch_unit #(.ADDR_W(8), .DEPTH(DEPTH), .RESET_ADDR(8'h00)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_instr_read(instr_read),
        .o_instr_ready(instr_ready), .o_opcode(opcode), .o_arg1(arg1), .o_arg2(arg2),
        .o_instr_addr(instr_addr), .o_mem_req(mem_req), .o_mem_addr(mem_addr),
        .i_mem_ready(mem_ready), .i_mem_data(mem_data),
        .i_redirect(redirect), .i_redirect_addr(redirect_addr)
    );

    instr_fetch_unit #(.ADDR_W(8), .DEPTH(DEPTH), .RESET_ADDR(8'hFE)) dut_wrap (
        .i_clk(clk), .i_rst_n(rst_n), .i_instr_read(1'b0),
        .o_instr_ready(wp_instr_ready), .o_opcode(wp_opcode), .o_arg1(wp_arg1), .o_arg2(wp_arg2),
        .o_instr_addr(wp_instr_addr), .o_mem_req(wp_mem_req), .o_mem_addr(wp_mem_addr),
        .i_mem_ready(1'b1), .i_mem_data(wp_mem_data),
        .i_redirect(1'b0), .i_redirect_addr(8'h00)
    );

    // Expected {opcode, arg1, arg2, addr} for an instruction starting at a
    function automatic logic [31:0] exp_head(input logic [7:0] a);
        logic [7:0] a1, a2;
        a1 = a + 8'd1;
        a2 = a + 8'd2;
        return {mem[a], mem[a1], mem[a2], a};
    endfunction

    // One clock; the model consumes the events visible just before the edge
    task automatic tick();
        logic       beat, pop, redir;
        logic [7:0] raddr;
        beat  = mem_req && mem_ready;
        pop   = (exp_q.size() != 0) && instr_read;
        redir = redirect;
        raddr = redirect_addr;
        @(posedge clk);
        if (redir) begin
            exp_q.delete();
            beat_idx = 0;
            model_pc = raddr;
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (beat) begin
                if (beat_idx == 0) cur_addr = model_pc;
                model_pc = model_pc + 8'd1;
                if (beat_idx == 2) begin
                    exp_q.push_back(cur_addr);
                    beat_idx = 0;
                end else begin
                    beat_idx++;
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        instr_read    = 1'b0;
        mem_ready     = 1'b0;
        redirect      = 1'b0;
        redirect_addr = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        beat_idx = 0;
        model_pc = 8'h00;
        rst_n    = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        total_cnt++;
        if ({instr_ready, mem_req} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {instr_ready, mem_req});
        else pass_cnt++;
        total_cnt++;
        if ({opcode, arg1, arg2, instr_addr, mem_addr} !== 40'h0) $display("FAIL reset_data: got %h want 0", {opcode, arg1, arg2, instr_addr, mem_addr});
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        do_reset();
        mem_ready = 1'b0;
        tick();
        total_cnt++;
        if (mem_req !== 1'b1) $display("FAIL async_setup_req: got %b want 1", mem_req);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (mem_req !== 1'b0) $display("FAIL async_req_drop: got %b want 0", mem_req);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        do_reset();
        mem_ready = 1'b1;
        tick();
        for (int k = 0; k < 6; k++) begin
            total_cnt++;
            if (mem_req !== 1'b1 || mem_addr !== 8'(k)) $display("FAIL basic_addr[%0d]: got req=%b addr=%h want req=1 addr=%h", k, mem_req, mem_addr, 8'(k));
            else pass_cnt++;
            tick();
            total_cnt++;
            if (instr_ready !== 1'(k >= 2)) $display("FAIL basic_ready[%0d]: got %b want %b", k, instr_ready, 1'(k >= 2));
            else pass_cnt++;
        end
        total_cnt++;
        if ({opcode, arg1, arg2, instr_addr} !== 32'h07010200) $display("FAIL basic_head: got %h want 07010200", {opcode, arg1, arg2, instr_addr});
        else pass_cnt++;
    endtask

    task automatic test_fill();
        int beats;
        do_reset();
        mem_ready = 1'b1;
        beats = 0;
        for (int c = 0; c < 40; c++) begin
            if (mem_req) beats++;
            tick();
        end
        total_cnt++;
        if (beats !== 12) $display("FAIL fill_beats: got %0d want 12", beats);
        else pass_cnt++;
        total_cnt++;
        if (mem_req !== 1'b0 || instr_ready !== 1'b1) $display("FAIL fill_idle: got req=%b ready=%b want req=0 ready=1", mem_req, instr_ready);
        else pass_cnt++;
        instr_read = 1'b1;
        tick();
        instr_read = 1'b0;
        total_cnt++;
        if (mem_req !== 1'b1 || mem_addr !== 8'd12) $display("FAIL fill_restart: got req=%b addr=%h want req=1 addr=0c", mem_req, mem_addr);
        else pass_cnt++;
        total_cnt++;
        if ({opcode, arg1, arg2, instr_addr} !== exp_head(8'd3)) $display("FAIL fill_head: got %h want %h", {opcode, arg1, arg2, instr_addr}, exp_head(8'd3));
        else pass_cnt++;
    endtask

    task automatic test_wait();
        int stable;
        do_reset();
        mem_ready = 1'b1;
        tick();
        tick();
        mem_ready = 1'b0;
        stable = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (mem_req === 1'b1 && mem_addr === 8'd1) stable++;
        end
        total_cnt++;
        if (stable !== 5) $display("FAIL wait_stable: got %0d stable cycles want 5", stable);
        else pass_cnt++;
        total_cnt++;
        if (instr_ready !== 1'b0) $display("FAIL wait_not_ready: got %b want 0", instr_ready);
        else pass_cnt++;
        mem_ready = 1'b1;
        tick();
        tick();
        mem_ready = 1'b0;
        total_cnt++;
        if (instr_ready !== 1'b1 || {opcode, arg1, arg2, instr_addr} !== 32'h07010200) $display("FAIL wait_head: got ready=%b %h want ready=1 07010200", instr_ready, {opcode, arg1, arg2, instr_addr});
        else pass_cnt++;
    endtask

    task automatic test_redirect();
        do_reset();
        mem_ready = 1'b1;
        repeat (5) tick();
        total_cnt++;
        if (mem_addr !== 8'd4 || instr_ready !== 1'b1) $display("FAIL redir_setup: got addr=%h ready=%b want addr=04 ready=1", mem_addr, instr_ready);
        else pass_cnt++;
        redirect      = 1'b1;
        redirect_addr = 8'h40;
        instr_read    = 1'b1;
        tick();
        redirect   = 1'b0;
        instr_read = 1'b0;
        total_cnt++;
        if (instr_ready !== 1'b0 || mem_req !== 1'b0) $display("FAIL redir_flush: got ready=%b req=%b want 0 0", instr_ready, mem_req);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h40) $display("FAIL redir_addr: got req=%b addr=%h want req=1 addr=40", mem_req, mem_addr);
        else pass_cnt++;
        repeat (3) tick();
        total_cnt++;
        if (instr_ready !== 1'b1 || {opcode, arg1, arg2, instr_addr} !== exp_head(8'h40)) $display("FAIL redir_head: got ready=%b %h want ready=1 %h", instr_ready, {opcode, arg1, arg2, instr_addr}, exp_head(8'h40));
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        logic [7:0] seen [3];
        logic [7:0] want [3];
        int         n;
        want[0] = 8'hFE;
        want[1] = 8'hFF;
        want[2] = 8'h00;
        do_reset();
        n = 0;
        for (int c = 0; c < 20 && n < 3; c++) begin
            if (wp_mem_req) begin
                seen[n] = wp_mem_addr;
                n++;
            end
            tick();
        end
        total_cnt++;
        if (n !== 3) $display("FAIL wrap_beats: got %0d want 3", n);
        else pass_cnt++;
        for (int i = 0; i < n; i++) begin
            total_cnt++;
            if (seen[i] !== want[i]) $display("FAIL wrap_addr[%0d]: got %h want %h", i, seen[i], want[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (wp_instr_ready !== 1'b1 || {wp_opcode, wp_arg1, wp_arg2, wp_instr_addr} !== exp_head(8'hFE)) $display("FAIL wrap_head: got ready=%b %h want ready=1 %h", wp_instr_ready, {wp_opcode, wp_arg1, wp_arg2, wp_instr_addr}, exp_head(8'hFE));
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int pops, last;
        do_reset();
        mem_ready  = 1'b1;
        instr_read = 1'b1;
        pops = 0;
        last = -1;
        for (int c = 0; c < 200 && pops < 20; c++) begin
            total_cnt++;
            if (instr_ready !== (exp_q.size() != 0)) $display("FAIL b2b_ready: got %b want %b", instr_ready, exp_q.size() != 0);
            else pass_cnt++;
            if (instr_ready && exp_q.size() != 0) begin
                total_cnt++;
                if ({opcode, arg1, arg2, instr_addr} !== exp_head(exp_q[0])) $display("FAIL b2b_head[%0d]: got %h want %h", pops, {opcode, arg1, arg2, instr_addr}, exp_head(exp_q[0]));
                else pass_cnt++;
                if (last >= 0) begin
                    total_cnt++;
                    if (c - last !== 3) $display("FAIL b2b_gap[%0d]: got %0d want 3", pops, c - last);
                    else pass_cnt++;
                end
                last = c;
                pops++;
            end
            tick();
        end
        total_cnt++;
        if (pops !== 20) $display("FAIL b2b_count: got %0d want 20", pops);
        else pass_cnt++;
        instr_read = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            mem_ready     = ($urandom_range(0, 3) != 0);
            instr_read    = ($urandom_range(0, 2) == 0);
            redirect      = ($urandom_range(0, 40) == 0);
            redirect_addr = 8'($urandom);
            total_cnt++;
            if (instr_ready !== (exp_q.size() != 0)) $display("FAIL rnd_ready[%0d]: got %b want %b", c, instr_ready, exp_q.size() != 0);
            else pass_cnt++;
            if (mem_req) begin
                total_cnt++;
                if (mem_addr !== model_pc) $display("FAIL rnd_addr[%0d]: got %h want %h", c, mem_addr, model_pc);
                else pass_cnt++;
            end
            if (exp_q.size() == DEPTH && beat_idx == 0) begin
                total_cnt++;
                if (mem_req !== 1'b0) $display("FAIL rnd_full_req[%0d]: got %b want 0", c, mem_req);
                else pass_cnt++;
            end
            if (exp_q.size() != 0) begin
                total_cnt++;
                if ({opcode, arg1, arg2, instr_addr} !== exp_head(exp_q[0])) $display("FAIL rnd_head[%0d]: got %h want %h", c, {opcode, arg1, arg2, instr_addr}, exp_head(exp_q[0]));
                else pass_cnt++;
            end
            tick();
        end
        redirect   = 1'b0;
        instr_read = 1'b0;
        mem_ready  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n         = 1'b0;
        instr_read    = 1'b0;
        mem_ready     = 1'b0;
        redirect      = 1'b0;
        redirect_addr = 8'h00;
        model_pc      = 8'h00;
        cur_addr      = 8'h00;
        beat_idx      = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h07; mem[1] = 8'h01; mem[2] = 8'h02;
        mem[3] = 8'h08; mem[4] = 8'h03; mem[5] = 8'h04;

        test_reset();
        test_async_reset();
        test_basic();
        test_fill();
        test_wait();
        test_redirect();
        test_wrap();
        test_back_to_back();
        test_random();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
